// File: rtl/mcb_pkg.sv
// mcb_pkg: shared encodings and types for the MCB port responder.
//   - command instruction encodings
//   - engine state enum
//   - packed command / write-data FIFO entry layouts
package mcb_pkg;

    localparam logic [2:0] MCB_WR      = 3'b000;
    localparam logic [2:0] MCB_WR_AP   = 3'b010;
    localparam logic [2:0] MCB_RD      = 3'b001;
    localparam logic [2:0] MCB_RD_AP   = 3'b011;
    localparam logic [2:0] MCB_REFRESH = 3'b100;

    // {instr, bl, byte_addr}
    localparam int MCB_CMD_W = 41;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } eng_state_e;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [31:0] addr;
    } mcb_cmd_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } mcb_wr_t;

endpackage

// File: rtl/mcb_sync_fifo.sv
// mcb_sync_fifo: single-clock show-ahead FIFO.
//   push/din   : write side; a push while full is ignored
//   pop        : read side; a pop while empty is ignored
//   dout       : head entry, forced to zero while empty
//   full/empty : registered status flags
//   count      : registered occupancy (0..DEPTH)
module mcb_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_nxt;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage is not reset; the empty mask keeps stale entries off dout.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mcb_port_responder.sv
// mcb_port_responder: block-RAM backed stand-in for an MCB DDR user port.
//   cmd_*  : command FIFO push side and status
//   wr_*   : write-data FIFO push side, status, underrun pulse, sticky error
//   rd_*   : read-data FIFO pop side (show-ahead), status, overflow pulse,
//            sticky error
// A single engine pops commands and runs write/read bursts against the RAM.
module mcb_port_responder
    import mcb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 10,
    parameter  int FIFO_DEPTH = 64,
    parameter  int CMD_DEPTH  = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // command port
    input  logic             cmd_en,
    input  logic [2:0]       cmd_instr,
    input  logic [5:0]       cmd_bl,
    input  logic [31:0]      cmd_byte_addr,
    output logic             cmd_empty,
    output logic             cmd_full,
    // write data port
    input  logic             wr_en,
    input  logic [3:0]       wr_mask,
    input  logic [31:0]      wr_data,
    output logic             wr_empty,
    output logic             wr_full,
    output logic             wr_underrun,
    output logic [CNT_W-1:0] wr_count,
    output logic             wr_error,
    // read data port
    input  logic             rd_en,
    output logic [31:0]      rd_data,
    output logic             rd_empty,
    output logic             rd_full,
    output logic             rd_overflow,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_error
);

    eng_state_e            state;
    logic [5:0]            beat_cnt;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  rd_pend;     // RAM read issued last cycle
    logic [31:0]           ram_q;
    logic [31:0]           ram [2**ADDR_WIDTH];

    mcb_cmd_t              cmd_in;
    mcb_cmd_t              cmd_head;
    mcb_wr_t               wr_in;
    mcb_wr_t               wr_head;
    logic                  cmd_pop;
    logic                  wr_pop;
    logic                  ram_rd;
    logic [$clog2(CMD_DEPTH):0] cmd_count_unused;
    logic                  unused_bits;

    assign cmd_in  = '{instr: cmd_instr, bl: cmd_bl, addr: cmd_byte_addr};
    assign wr_in   = '{mask: wr_mask, data: wr_data};

    assign cmd_pop = (state == ST_IDLE)  && !cmd_empty;
    assign wr_pop  = (state == ST_WRITE) && !wr_empty;
    assign ram_rd  = (state == ST_READ);

    mcb_sync_fifo #(.WIDTH(MCB_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_en),
        .din   (cmd_in),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count_unused)
    );

    mcb_sync_fifo #(.WIDTH(36), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .din   (wr_in),
        .pop   (wr_pop),
        .dout  (wr_head),
        .full  (wr_full),
        .empty (wr_empty),
        .count (wr_count)
    );

    // Read data lands one cycle after issue; the FIFO itself drops it if full.
    mcb_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend),
        .din   (ram_q),
        .pop   (rd_en),
        .dout  (rd_data),
        .full  (rd_full),
        .empty (rd_empty),
        .count (rd_count)
    );

    // Backing RAM: byte-enabled write at the pop edge, registered read.
    always_ff @(posedge clk) begin
        if (wr_pop) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_head.mask[b]) ram[waddr][8*b +: 8] <= wr_head.data[8*b +: 8];
            end
        end
        if (ram_rd) ram_q <= ram[waddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            waddr       <= '0;
            rd_pend     <= 1'b0;
            wr_underrun <= 1'b0;
            rd_overflow <= 1'b0;
            wr_error    <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            rd_pend     <= ram_rd;
            wr_underrun <= (state == ST_WRITE) && wr_empty;
            rd_overflow <= rd_pend && rd_full;
            if ((wr_en && wr_full) || ((state == ST_WRITE) && wr_empty)) wr_error <= 1'b1;
            if ((rd_en && rd_empty) || (rd_pend && rd_full))             rd_error <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_pop) begin
                        beat_cnt <= cmd_head.bl;
                        waddr    <= cmd_head.addr[ADDR_WIDTH+1:2];
                        // Refresh and unknown codes are consumed without a burst.
                        if (!cmd_head.instr[2])
                            state <= cmd_head.instr[0] ? ST_READ : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_pop) begin
                        waddr <= waddr + 1'b1;
                        if (beat_cnt == '0) state    <= ST_IDLE;
                        else                beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                ST_READ: begin
                    waddr <= waddr + 1'b1;
                    if (beat_cnt == '0) state    <= ST_IDLE;
                    else                beat_cnt <= beat_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address bits outside the RAM range and instr[1] carry no meaning here.
    assign unused_bits = ^{cmd_count_unused, cmd_head.addr, cmd_head.instr[1]};

endmodule
